// File: rtl/multi_channel_health_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_channel_health_monitor                                               |
// | Per-channel clipping / sustained-envelope fault monitor on a TDM sample bus.|
// | Optional auto-recovery: HEALTH_MON_AUTO_RECOVER_EN                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multi_channel_health_monitor #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CH       = 4,
  parameter int PEAK_RUN   = 10,
  parameter int ENV_RUN    = 32,
  parameter int ENV_SHIFT  = 3,
  parameter int CNT_W      = 16,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic [CH_W-1:0]       sample_ch,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic [DATA_WIDTH-1:0] env_threshold,
  input  logic [CNT_W-1:0]      recover_len,
  input  logic                  clear_faults,
  output logic [N_CH-1:0]       health,
  output logic                  health_all,
  output logic [N_CH-1:0]       peak_fault,
  output logic [N_CH-1:0]       envl_fault,
  output logic [DATA_WIDTH-1:0] env_mon
);

  localparam logic [DATA_WIDTH-1:0] c_pos_max  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_neg_min  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]      c_peak_run = CNT_W'(PEAK_RUN);
  localparam logic [CNT_W-1:0]      c_env_run  = CNT_W'(ENV_RUN);

  // Per-channel state
  logic [N_CH-1:0][DATA_WIDTH-1:0] r_env;
  logic [N_CH-1:0][CNT_W-1:0]      r_peak_cnt;
  logic [N_CH-1:0][CNT_W-1:0]      r_env_cnt;
  logic [N_CH-1:0]                 r_peak_fault;
  logic [N_CH-1:0]                 r_envl_fault;
  logic [DATA_WIDTH-1:0]           r_env_mon;

  // Pipeline registers
  logic                  r_s0_valid;
  logic [CH_W-1:0]       r_s0_ch;
  logic [DATA_WIDTH-1:0] r_s0_abs;
  logic                  r_s0_fs;
  logic                  r_s1_valid;
  logic [CH_W-1:0]       r_s1_ch;
  logic [DATA_WIDTH-1:0] r_s1_env;
  logic                  r_s1_fs;
  logic                  r_s1_peak_hit;

  logic                  w_ch_ok;
  logic [DATA_WIDTH-1:0] w_abs;
  logic                  w_full_scale;
  logic [DATA_WIDTH-1:0] w_env_old;
  logic [DATA_WIDTH-1:0] w_env_new;
  logic [CNT_W-1:0]      w_peak_old;
  logic [CNT_W-1:0]      w_peak_new;
  logic                  w_above;
  logic [CNT_W-1:0]      w_envc_old;
  logic [CNT_W-1:0]      w_envc_new;
  logic                  w_envl_hit;
  logic                  w_recover;

  generate
    if ((1 << CH_W) == N_CH) begin : g_ch_full
      assign w_ch_ok = 1'b1;
    end else begin : g_ch_range
      assign w_ch_ok = (32'(sample_ch) < N_CH);
    end
  endgenerate

  // S0: magnitude with the most negative code saturated to full-scale positive
  always_comb begin
    w_full_scale = (sample_in == c_pos_max) || (sample_in == c_neg_min);
    if (sample_in == c_neg_min)
      w_abs = c_pos_max;
    else if (sample_in[DATA_WIDTH-1])
      w_abs = -sample_in;
    else
      w_abs = sample_in;
  end

  // S1: state written here is read here, so back-to-back samples see fresh values
  always_comb begin
    w_env_old  = r_env[r_s0_ch];
    w_env_new  = w_env_old - (w_env_old >> ENV_SHIFT) + (r_s0_abs >> ENV_SHIFT);
    w_peak_old = r_peak_cnt[r_s0_ch];
    if (!r_s0_fs)
      w_peak_new = '0;
    else if (w_peak_old >= c_peak_run)
      w_peak_new = c_peak_run;
    else
      w_peak_new = w_peak_old + 1'b1;
  end

  always_comb begin
    w_above    = (r_s1_env > env_threshold);
    w_envc_old = r_env_cnt[r_s1_ch];
    if (!w_above)
      w_envc_new = '0;
    else if (w_envc_old >= c_env_run)
      w_envc_new = c_env_run;
    else
      w_envc_new = w_envc_old + 1'b1;
    w_envl_hit = (w_envc_new == c_env_run);
  end

`ifdef HEALTH_MON_AUTO_RECOVER_EN
  logic [N_CH-1:0][CNT_W-1:0] r_rec_cnt;
  logic [CNT_W-1:0]           w_rec_new;

  always_comb begin
    w_rec_new = '0;
    w_recover = 1'b0;
    if ((r_peak_fault[r_s1_ch] || r_envl_fault[r_s1_ch]) && !r_s1_fs && !w_above) begin
      w_rec_new = (r_rec_cnt[r_s1_ch] == '1) ? r_rec_cnt[r_s1_ch] : r_rec_cnt[r_s1_ch] + 1'b1;
      w_recover = (recover_len != '0) && (w_rec_new >= recover_len);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_faults)
      r_rec_cnt <= '0;
    else if (enable && r_s1_valid)
      r_rec_cnt[r_s1_ch] <= w_recover ? '0 : w_rec_new;
  end
`else
  logic w_unused_recover_len;
  assign w_unused_recover_len = ^recover_len;
  assign w_recover            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || clear_faults) begin
      r_s0_valid    <= 1'b0;
      r_s0_ch       <= '0;
      r_s0_abs      <= '0;
      r_s0_fs       <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s1_ch       <= '0;
      r_s1_env      <= '0;
      r_s1_fs       <= 1'b0;
      r_s1_peak_hit <= 1'b0;
      r_env         <= '0;
      r_peak_cnt    <= '0;
      r_env_cnt     <= '0;
      r_peak_fault  <= '0;
      r_envl_fault  <= '0;
      r_env_mon     <= '0;
    end else if (enable) begin
      r_s0_valid    <= sample_valid && w_ch_ok;
      r_s0_ch       <= sample_ch;
      r_s0_abs      <= w_abs;
      r_s0_fs       <= w_full_scale;
      r_s1_valid    <= r_s0_valid;
      r_s1_ch       <= r_s0_ch;
      r_s1_env      <= w_env_new;
      r_s1_fs       <= r_s0_fs;
      r_s1_peak_hit <= r_s0_fs && (w_peak_new == c_peak_run);

      if (r_s1_valid) begin
        if (w_recover) begin
          r_peak_fault[r_s1_ch] <= 1'b0;
          r_envl_fault[r_s1_ch] <= 1'b0;
          r_env_cnt[r_s1_ch]    <= '0;
          r_peak_cnt[r_s1_ch]   <= '0;
        end else begin
          r_env_cnt[r_s1_ch] <= w_envc_new;
          if (r_s1_peak_hit)
            r_peak_fault[r_s1_ch] <= 1'b1;
          if (w_envl_hit)
            r_envl_fault[r_s1_ch] <= 1'b1;
        end
      end

      // Placed after S2 so an S1 update to the same channel takes precedence
      if (r_s0_valid) begin
        r_env[r_s0_ch]      <= w_env_new;
        r_peak_cnt[r_s0_ch] <= w_peak_new;
        r_env_mon           <= w_env_new;
      end
    end
  end

  assign peak_fault = r_peak_fault;
  assign envl_fault = r_envl_fault;
  assign health     = ~(r_peak_fault | r_envl_fault);
  assign health_all = &health;
  assign env_mon    = r_env_mon;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_health_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multi_channel_health_monitor                                            |
// | Directed self-checking bench for multi_channel_health_monitor.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multi_channel_health_monitor;

  logic               clk = 1'b0;
  logic               reset, enable, sample_valid, clear_faults;
  logic [1:0]         sample_ch;
  logic signed [15:0] sample_in;
  logic [15:0]        env_threshold, recover_len;
  logic [3:0]         health, peak_fault, envl_fault;
  logic               health_all;
  logic [15:0]        env_mon;

  logic               valid_b;
  logic [2:0]         ch_b;
  logic [4:0]         health_b, peak_b, envl_b;
  logic               health_all_b;
  logic [15:0]        env_mon_b;

`ifdef HEALTH_MON_AUTO_RECOVER_EN
  localparam logic [3:0] c_rec_health = 4'b1111;
  localparam logic [3:0] c_rec_peak   = 4'b0000;
`else
  localparam logic [3:0] c_rec_health = 4'b1011;
  localparam logic [3:0] c_rec_peak   = 4'b0100;
`endif

  multi_channel_health_monitor #(
    .DATA_WIDTH(16), .N_CH(4), .PEAK_RUN(10), .ENV_RUN(32), .ENV_SHIFT(3), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_in(sample_in), .env_threshold(env_threshold),
    .recover_len(recover_len), .clear_faults(clear_faults), .health(health),
    .health_all(health_all), .peak_fault(peak_fault), .envl_fault(envl_fault),
    .env_mon(env_mon)
  );

  // Channel 5 cannot be expressed on a 2-bit index, so a 5-channel instance covers the drop path
  multi_channel_health_monitor #(
    .DATA_WIDTH(16), .N_CH(5), .PEAK_RUN(10), .ENV_RUN(32), .ENV_SHIFT(3), .CNT_W(16)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(valid_b),
    .sample_ch(ch_b), .sample_in(sample_in), .env_threshold(env_threshold),
    .recover_len(recover_len), .clear_faults(clear_faults), .health(health_b),
    .health_all(health_all_b), .peak_fault(peak_b), .envl_fault(envl_b),
    .env_mon(env_mon_b)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: processes samples in order, one at a time
  logic [15:0] m_env [4];
  int          m_pc  [4];
  int          m_ec  [4];
  int          m_rc  [4];
  logic [3:0]  m_pf, m_ef;
  logic [15:0] m_mon;
  logic [15:0] mon9;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_env[i] = '0; m_pc[i] = 0; m_ec[i] = 0; m_rc[i] = 0;
    end
    m_pf = '0; m_ef = '0; m_mon = '0;
  endtask

  task automatic model_step(input int ch, input logic signed [15:0] x);
    logic [15:0] a;
    logic        fs, above, faulted;
    fs = (x == 16'sh7FFF) || (x == -16'sh8000);
    if (x == -16'sh8000) a = 16'h7FFF;
    else if (x < 0)      a = 16'(-x);
    else                 a = 16'(x);
    m_env[ch] = m_env[ch] - (m_env[ch] >> 3) + (a >> 3);
    m_mon     = m_env[ch];
    m_pc[ch]  = fs ? ((m_pc[ch] < 10) ? m_pc[ch] + 1 : 10) : 0;
    above     = (m_env[ch] > env_threshold);
    m_ec[ch]  = above ? ((m_ec[ch] < 32) ? m_ec[ch] + 1 : 32) : 0;
    faulted   = m_pf[ch] | m_ef[ch];
    if (m_pc[ch] == 10) m_pf[ch] = 1'b1;
    if (m_ec[ch] == 32) m_ef[ch] = 1'b1;
`ifdef HEALTH_MON_AUTO_RECOVER_EN
    if (faulted && !fs && !above) begin
      m_rc[ch]++;
      if (recover_len != 0 && m_rc[ch] >= int'(recover_len)) begin
        m_pf[ch] = 1'b0; m_ef[ch] = 1'b0;
        m_pc[ch] = 0; m_ec[ch] = 0; m_rc[ch] = 0;
      end
    end else begin
      m_rc[ch] = 0;
    end
`else
    m_rc[ch] = faulted ? 0 : 0;
`endif
  endtask

  int          q_ch[$];
  logic [15:0] q_x[$];

  task automatic push(input int ch, input int x, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      q_ch.push_back(ch);
      q_x.push_back(16'(x));
    end
  endtask

  // Streams the queue back-to-back, checking every cycle against model snapshots
  task automatic run_stream(input string tag);
    logic [15:0] h_mon[$];
    logic [3:0]  h_pf[$];
    logic [3:0]  h_ef[$];
    int n;
    n = q_ch.size();
    h_mon.push_back(m_mon); h_pf.push_back(m_pf); h_ef.push_back(m_ef);
    for (int k = 0; k < n + 2; k++) begin
      int mi, fi;
      logic [3:0] eh;
      if (k < n) begin
        sample_valid = 1'b1;
        sample_ch    = 2'(q_ch[k]);
        sample_in    = q_x[k];
        model_step(q_ch[k], q_x[k]);
        h_mon.push_back(m_mon); h_pf.push_back(m_pf); h_ef.push_back(m_ef);
      end else begin
        sample_valid = 1'b0;
      end
      tick();
      mi = (k < n) ? k : n;
      fi = (k == 0) ? 0 : ((k - 1 < n) ? k - 1 : n);
      eh = ~(h_pf[fi] | h_ef[fi]);
      check({tag, "/mon"},  env_mon,    h_mon[mi]);
      check({tag, "/pf"},   peak_fault, h_pf[fi]);
      check({tag, "/ef"},   envl_fault, h_ef[fi]);
      check({tag, "/hl"},   health,     eh);
      check({tag, "/hall"}, health_all, &eh);
    end
    q_ch.delete();
    q_x.delete();
  endtask

  task automatic do_clear();
    clear_faults = 1'b1;
    tick();
    clear_faults = 1'b0;
    model_clear();
    check("clr_mon", env_mon, 16'h0000);
    check("clr_hl",  health,  4'hF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b1; sample_valid = 1'b0; sample_ch = '0; sample_in = '0;
    clear_faults = 1'b0; env_threshold = 16'hFFFF; recover_len = 16'd100;
    valid_b = 1'b0; ch_b = '0;
    repeat (3) tick();
    reset = 1'b0;
    model_clear();
    check("rst_hl",   health,     4'hF);
    check("rst_hall", health_all, 1'b1);
    check("rst_pf",   peak_fault, 4'h0);
    check("rst_ef",   envl_fault, 4'h0);
    check("rst_mon",  env_mon,    16'h0000);
    check("rst_hl_b", health_b,   5'h1F);

    // Clipping on ch2 with exact 3-cycle latency
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1; sample_ch = 2'd2; sample_in = 16'sh7FFF;
      model_step(2, 16'sh7FFF);
      tick();
    end
    sample_valid = 1'b0;
    tick();
    check("clip_early", peak_fault, 4'b0000);
    tick();
    check("clip_pf",   peak_fault, 4'b0100);
    check("clip_hl",   health,     4'b1011);
    check("clip_hall", health_all, 1'b0);
    check("clip_ef",   envl_fault, 4'b0000);

    // Broken run of negative full scale, then one more to complete a run
    do_clear();
    push(1, -32768, 9); push(1, 0, 1); push(1, -32768, 9);
    run_stream("brk");
    check("brk_pf", peak_fault, 4'b0000);
    push(1, -32768, 1);
    run_stream("brk10");
    check("brk10_pf", peak_fault, 4'b0010);

    // Envelope on ch0
    do_clear();
    env_threshold = 16'd16384;
    push(0, 30000, 1); run_stream("env1");
    check("env1_mon", env_mon, 16'd3750);
    push(0, 30000, 1); run_stream("env2");
    check("env2_mon", env_mon, 16'd7032);
    push(0, 30000, 34); run_stream("env36");
    check("env36_ef", envl_fault, 4'b0000);
    push(0, 30000, 1); run_stream("env37");
    check("env37_ef", envl_fault, 4'b0001);
    check("env37_hl", health,     4'b1110);

    // Interleave ch0/ch3, then ch0 every cycle
    do_clear();
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) push(0, 32767, 1);
      else            push(3, (k < 16) ? -32768 : 1000, 1);
    end
    push(0, 28000, 40);
    run_stream("ilv");
    check("ilv_pf", peak_fault, 4'b0001);
    check("ilv_ef", envl_fault, 4'b0001);

    // Enable low for 5 cycles stretches latency
    do_clear();
    env_threshold = 16'hFFFF;
    mon9 = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) mon9 = m_mon;
      sample_valid = 1'b1; sample_ch = 2'd1; sample_in = 16'sh7FFF;
      model_step(1, 16'sh7FFF);
      tick();
    end
    sample_valid = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_hold_pf",  peak_fault, 4'b0000);
      check("en_hold_mon", env_mon,    mon9);
    end
    enable = 1'b1;
    tick();
    check("en_late_pf",  peak_fault, 4'b0000);
    check("en_late_mon", env_mon,    m_mon);
    tick();
    check("en_pf", peak_fault, 4'b0010);

    // clear_faults alongside the 10th clipped sample
    do_clear();
    for (int i = 0; i < 9; i++) begin
      sample_valid = 1'b1; sample_ch = 2'd2; sample_in = 16'sh7FFF;
      tick();
    end
    clear_faults = 1'b1;
    tick();
    clear_faults = 1'b0; sample_valid = 1'b0;
    model_clear();
    repeat (3) tick();
    check("cw_pf",   peak_fault, 4'b0000);
    check("cw_hl",   health,     4'hF);
    check("cw_hall", health_all, 1'b1);
    check("cw_mon",  env_mon,    16'h0000);
    push(2, 32767, 9); run_stream("cw9");
    check("cw9_pf", peak_fault, 4'b0000);
    push(2, 32767, 1); run_stream("cw10");
    check("cw10_pf", peak_fault, 4'b0100);

    // Recovery (or persistence when the feature is compiled out)
    do_clear();
    env_threshold = 16'hFFFF;
    recover_len   = 16'd100;
    push(2, 32767, 10); run_stream("rc_flt");
    check("rc_flt_pf", peak_fault, 4'b0100);
    push(2, 0, 99); run_stream("rc_99");
    check("rc_99_hl", health, 4'b1011);
    push(2, 32767, 1); run_stream("rc_clip");
    check("rc_clip_hl", health, 4'b1011);
    push(2, 0, 99); run_stream("rc_99b");
    check("rc_99b_hl", health, 4'b1011);
    push(2, 0, 1); run_stream("rc_100");
    check("rc_100_hl", health,     c_rec_health);
    check("rc_100_pf", peak_fault, c_rec_peak);

    // Out-of-range channel indices are dropped
    do_clear();
    for (int k = 0; k < 30; k++) begin
      valid_b = 1'b1; ch_b = 3'(5 + k % 3); sample_in = 16'sh7FFF;
      tick();
    end
    valid_b = 1'b0;
    repeat (3) tick();
    check("drop_pf",   peak_b,       5'b00000);
    check("drop_ef",   envl_b,       5'b00000);
    check("drop_mon",  env_mon_b,    16'h0000);
    check("drop_hall", health_all_b, 1'b1);
    for (int k = 0; k < 10; k++) begin
      valid_b = 1'b1; ch_b = 3'd4; sample_in = 16'sh7FFF;
      tick();
    end
    valid_b = 1'b0;
    repeat (3) tick();
    check("ch4_pf", peak_b, 5'b10000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
